// File: rtl/freq_sched_pkg.sv
// rtl/freq_sched_pkg.sv - shared types and defaults for the frequency/phase divider scheduler
package freq_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    DONE   = 2'd2
  } sched_state_e;

  // Timer runs at 1 ns per tick, so frequency = TIMER_TICKS_PER_S / period.
  localparam int unsigned TIMER_TICKS_PER_S = 1_000_000_000;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_NUM_REQ = 3;

endpackage

// File: rtl/serial_divider.sv
// rtl/serial_divider.sv - restoring unsigned divider, one quotient bit per cycle, MSB first
module serial_divider
  import freq_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             start,
  input  logic [WIDTH-1:0] num,
  input  logic [WIDTH-1:0] den,
  output logic             busy,
  output logic             valid,
  output logic             dbz,
  output logic [WIDTH-1:0] quot
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q, quot_q, den_q;
  logic [WIDTH-1:0] rem_in, quot_in, den_use;
  logic [WIDTH-1:0] rem_nxt, quot_nxt;
  logic [WIDTH:0]   rem_sh, diff;
  logic             valid_q, dbz_q;

  // The first quotient bit is resolved in the start cycle straight from the
  // operands, so the result is ready WIDTH cycles after start.
  always_comb begin
    rem_in  = start ? '0  : rem_q;
    quot_in = start ? num : quot_q;
    den_use = start ? den : den_q;
    rem_sh  = {rem_in, quot_in[WIDTH-1]};
    diff    = rem_sh - {1'b0, den_use};
    if (!diff[WIDTH]) begin
      rem_nxt  = diff[WIDTH-1:0];
      quot_nxt = {quot_in[WIDTH-2:0], 1'b1};
    end else begin
      rem_nxt  = rem_sh[WIDTH-1:0];
      quot_nxt = {quot_in[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt_q   <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      den_q   <= '0;
      valid_q <= 1'b0;
      dbz_q   <= 1'b0;
    end else if (start) begin
      den_q <= den;
      if (den == '0) begin
        quot_q  <= '1;
        rem_q   <= '0;
        cnt_q   <= '0;
        valid_q <= 1'b1;
        dbz_q   <= 1'b1;
      end else begin
        rem_q   <= rem_nxt;
        quot_q  <= quot_nxt;
        cnt_q   <= CNT_W'(WIDTH - 1);
        valid_q <= 1'b0;
        dbz_q   <= 1'b0;
      end
    end else if (cnt_q != '0) begin
      rem_q   <= rem_nxt;
      quot_q  <= quot_nxt;
      cnt_q   <= cnt_q - 1'b1;
      valid_q <= (cnt_q == CNT_W'(1));
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign busy  = (cnt_q != '0);
  assign valid = valid_q;
  assign dbz   = dbz_q;
  assign quot  = quot_q;

endmodule

// File: rtl/freq_div_scheduler.sv
// rtl/freq_div_scheduler.sv - round-robin time-sharing of one serial divider among requesters
module freq_div_scheduler
  import freq_sched_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ*WIDTH-1:0] req_num_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_den_i,
  output logic [NUM_REQ-1:0]       rsp_valid_o,
  output logic [WIDTH-1:0]         rsp_quot_o,
  output logic                     rsp_dbz_o,
  output logic                     busy_o
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  typedef logic [PTR_W-1:0] idx_t;

  sched_state_e     state_q, state_d;
  idx_t             ptr_q, grant_q, grant_idx, cand_idx;
  logic             grant_any, hs, den_zero;
  logic [WIDTH-1:0] sel_num, sel_den;
  logic             div_busy, div_valid, div_dbz;
  logic [WIDTH-1:0] div_quot;
  int               cand;

  // Round-robin search starting at ptr_q; the first valid requester wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = idx_t'(cand);
      if (!grant_any && req_valid_i[cand_idx]) begin
        grant_any = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  assign hs       = (state_q == IDLE) && grant_any;
  assign sel_num  = req_num_i[int'(grant_idx)*WIDTH +: WIDTH];
  assign sel_den  = req_den_i[int'(grant_idx)*WIDTH +: WIDTH];
  assign den_zero = (sel_den == '0);

  serial_divider #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .start    (hs),
    .num      (sel_num),
    .den      (sel_den),
    .busy     (div_busy),
    .valid    (div_valid),
    .dbz      (div_dbz),
    .quot     (div_quot)
  );

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hs) state_d = den_zero ? DONE : DIVIDE;
      DIVIDE:  if (div_valid) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Response registers hold their value between responses; divide-by-zero
  // is known at the handshake and bypasses the divider entirely.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      ptr_q      <= '0;
      grant_q    <= '0;
      rsp_quot_o <= '0;
      rsp_dbz_o  <= 1'b0;
    end else begin
      if (hs) begin
        grant_q <= grant_idx;
        ptr_q   <= (grant_idx == idx_t'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        if (den_zero) begin
          rsp_quot_o <= '1;
          rsp_dbz_o  <= 1'b1;
        end
      end
      if (state_q == DIVIDE && div_valid) begin
        rsp_quot_o <= div_quot;
        rsp_dbz_o  <= div_dbz;
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    rsp_valid_o = '0;
    if (hs) req_ready_o = ONE_HOT0 << grant_idx;
    if (state_q == DONE) rsp_valid_o = ONE_HOT0 << grant_q;
    busy_o = (state_q != IDLE) || div_busy;
  end

endmodule

// File: tb/tb_freq_div_scheduler.sv
// tb/tb_freq_div_scheduler.sv - scoreboard bench for freq_div_scheduler
module tb_freq_div_scheduler;

  localparam int W = 32;
  localparam int N = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid, req_ready, rsp_valid;
  logic [N*W-1:0] req_num, req_den;
  logic [W-1:0]   rsp_quot;
  logic           rsp_dbz, busy;

  typedef struct {
    int         idx;
    logic [W-1:0] quot;
    logic       dbz;
    int         due;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];
  int   hs_log[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  freq_div_scheduler #(.WIDTH(W), .NUM_REQ(N)) dut (
    .clk_i       (clk),
    .reset_ni    (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_num_i   (req_num),
    .req_den_i   (req_den),
    .rsp_valid_o (rsp_valid),
    .rsp_quot_o  (rsp_quot),
    .rsp_dbz_o   (rsp_dbz),
    .busy_o      (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    logic [W-1:0] n, d;
    if (rst_n) begin
      for (int r = 0; r < N; r++) begin
        if (req_valid[r] && req_ready[r]) begin
          n = req_num[r*W +: W];
          d = req_den[r*W +: W];
          e.idx  = r;
          e.dbz  = (d == 0);
          e.quot = (d == 0) ? '1 : n / d;
          e.due  = cyc + ((d == 0) ? 1 : W + 1);
          sb.push_back(e);
          grant_log.push_back(r);
          hs_log.push_back(cyc);
        end
      end
      if (rsp_valid != '0) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 64'(rsp_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          check("rsp_onehot", 64'(rsp_valid), 64'(3'b001 << e.idx));
          check("rsp_cycle", 64'(cyc), 64'(e.due));
          check("rsp_quot", 64'(rsp_quot), 64'(e.quot));
          check("rsp_dbz", 64'(rsp_dbz), 64'(e.dbz));
        end
      end
    end
  end

  task automatic clear_logs();
    sb.delete();
    grant_log.delete();
    hs_log.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_logs();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic issue(input int r, input logic [W-1:0] n, input logic [W-1:0] d);
    bit ok = 1'b0;
    req_num[r*W +: W] = n;
    req_den[r*W +: W] = d;
    req_valid[r] = 1'b1;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge clk);
      if (req_ready[r] && rst_n) ok = 1'b1;
    end
    @(posedge clk);
    #1 req_valid[r] = 1'b0;
    if (!ok) check("issue_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) break;
    end
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  logic [W-1:0] edge_n [4] = '{32'd5, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [W-1:0] edge_d [4] = '{32'd7, 32'd3, 32'd1,         32'hFFFF_FFFF};
  logic [W-1:0] edge_q [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'd1};

  initial begin
    #1_500_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [W-1:0] rn, rd;
    int rr;
    rst_n = 1'b0;
    req_valid = '0;
    req_num = '0;
    req_den = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_quot", 64'(rsp_quot), 64'd0);
    check("rst_dbz", 64'(rsp_dbz), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready_idle", 64'(req_ready), 64'd0);
    req_valid = 3'b110;
    #1 check("rst_ready_comb", 64'(req_ready), 64'(3'b010));
    req_valid = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // single request, nominal frequency computation
    issue(0, 32'd1_000_000_000, 32'd1000);
    wait_idle();
    check("s1_quot", 64'(rsp_quot), 64'd1_000_000);

    // three requesters together right after reset
    @(posedge clk);
    #1 do_reset();
    fork
      issue(0, 32'd1_000_000_000, 32'd1000);
      issue(1, 32'd1_000_000_000, 32'd2000);
      issue(2, 32'd1_000_000_000, 32'd4000);
    join
    wait_idle();
    check("s2_ngrant", 64'(grant_log.size()), 64'd3);
    if (grant_log.size() == 3) begin
      for (int i = 0; i < 3; i++) check("s2_grant_order", 64'(grant_log[i]), 64'(i));
      check("s2_gap01", 64'(hs_log[1] - hs_log[0]), 64'(W + 2));
      check("s2_gap12", 64'(hs_log[2] - hs_log[1]), 64'(W + 2));
    end
    check("s2_last_quot", 64'(rsp_quot), 64'd250_000);

    // divide by zero, then a normal request clears the flag
    issue(1, 32'd5, 32'd0);
    wait_idle();
    check("s3_dbz_hold", 64'(rsp_dbz), 64'd1);
    check("s3_quot_hold", 64'(rsp_quot), 64'hFFFF_FFFF);
    issue(1, 32'd10, 32'd3);
    wait_idle();
    check("s3_dbz_clear", 64'(rsp_dbz), 64'd0);

    // two continuous requesters alternate
    @(posedge clk);
    #1 do_reset();
    fork
      begin repeat (3) issue(0, 32'd1000, 32'd7); end
      begin repeat (3) issue(2, 32'd999, 32'd9); end
    join
    wait_idle();
    check("s4_ngrant", 64'(grant_log.size()), 64'd6);
    if (grant_log.size() == 6)
      for (int i = 0; i < 6; i++) check("s4_rr_seq", 64'(grant_log[i]), 64'((i % 2) ? 2 : 0));

    // reset at cycle 10 of DIVIDE abandons the operation
    issue(0, 32'd1_000_000_000, 32'd3);
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    clear_logs();
    #1;
    check("s5_rst_valid", 64'(rsp_valid), 64'd0);
    check("s5_rst_quot", 64'(rsp_quot), 64'd0);
    check("s5_rst_dbz", 64'(rsp_dbz), 64'd0);
    check("s5_rst_busy", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1 issue(1, 32'd7, 32'd7);
    wait_idle();
    check("s5_quot", 64'(rsp_quot), 64'd1);

    // pointer returns to 0 after reset: req1 beats req2 even though ptr was 2
    issue(1, 32'd100, 32'd7);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    clear_logs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    fork
      issue(2, 32'd9, 32'd3);
      issue(1, 32'd8, 32'd2);
    join
    wait_idle();
    if (grant_log.size() > 0) check("s5_ptr_reset", 64'(grant_log[0]), 64'd1);
    else check("s5_ptr_reset_none", 64'd0, 64'd1);

    // boundary operands
    for (int i = 0; i < 4; i++) begin
      issue(0, edge_n[i], edge_d[i]);
      wait_idle();
      check("edge_quot", 64'(rsp_quot), 64'(edge_q[i]));
    end

    // random operands against the behavioural model in the monitor
    for (int i = 0; i < 1000; i++) begin
      rr = $urandom_range(0, N - 1);
      rn = $urandom;
      case ($urandom_range(0, 3))
        0:       rd = $urandom;
        1:       rd = $urandom_range(1, 255);
        2:       rd = rn >> $urandom_range(0, 31);
        default: rd = $urandom_range(0, 3);
      endcase
      issue(rr, rn, rd);
      wait_idle();
    end

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
